// File: rtl/pipe_ctrl.sv
// Pipeline controller: data-memory handshake FSM with timeout trap, stage enables,
// branch flush, EX operand forwarding select and a saturating frozen-cycle counter.
module pipe_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_is_load,
  input  logic             mem_is_store,
  input  logic             mem_reg_wr,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic             ex_use_rs1,
  input  logic             ex_use_rs2,
  input  logic             ex_br_taken,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_MWAIT, ST_ERR} state_t;

  localparam logic [7:0]       TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  state_t           state_q, state_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_acc;
  logic req_raw;
  logic advance;

  function automatic logic [1:0] fwd_sel(
    input logic       use_rs,
    input logic [4:0] rs,
    input logic       wr,
    input logic       ld,
    input logic [4:0] rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs && wr && (rd == rs) && (rd != 5'd0)) begin
      sel = ld ? 2'b10 : 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    mem_acc     = mem_is_load | mem_is_store;
    req_raw     = 1'b0;
    advance     = 1'b0;
    state_d     = state_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      ST_RUN: begin
        req_raw = mem_acc;
        advance = !mem_acc || dmem_ack;
        if (mem_acc && !dmem_ack) begin
          state_d = ST_MWAIT;
          tmo_d   = 8'd0;
        end
      end
      ST_MWAIT: begin
        req_raw = 1'b1;
        advance = dmem_ack;
        // An ack arriving on the last allowed cycle still completes the access.
        if (dmem_ack) begin
          state_d = ST_RUN;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_ERR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (!advance && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      tmo_q       <= 8'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dmem_req   = !rst && req_raw;
  assign pc_en      = !rst && advance;
  assign ifid_en    = !rst && advance;
  assign exmem_en   = !rst && advance;
  assign ifid_flush = !rst && advance && ex_br_taken;
  assign fwd_a      = rst ? 2'b00 : fwd_sel(ex_use_rs1, ex_rs1, mem_reg_wr, mem_is_load, mem_rd);
  assign fwd_b      = rst ? 2'b00 : fwd_sel(ex_use_rs2, ex_rs2, mem_reg_wr, mem_is_load, mem_rd);
  assign err        = err_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: max MWAIT cycles before the error trap; legal range 1..255.
REQ-002 Parameter CNT_W, default 16: width of stall_cnt.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 mem_is_load, mem_is_store  in  1 each  instruction in the EX_MEM register is a load / store; never both.
REQ-006 mem_reg_wr  in  1  instruction in EX_MEM writes rd.
REQ-007 mem_rd  in  5  rd of the instruction in EX_MEM.
REQ-008 ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX.
REQ-009 ex_use_rs1, ex_use_rs2  in  1 each  EX instruction reads rs1 / rs2.
REQ-010 ex_br_taken  in  1  branch/jump resolved taken in EX.
REQ-011 dmem_ack  in  1  data memory completes the current access this cycle.
REQ-012 dmem_req  out  1  data memory access request.
REQ-013 pc_en, ifid_en, exmem_en  out  1 each  load enables for PC, IF_ID and EX_MEM registers.
REQ-014 ifid_flush  out  1  replace IF_ID contents with NOP on the next edge.
REQ-015 fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 EX_MEM ALU result, 10 memory load data.
REQ-016 err  out  1  sticky memory-timeout error.
REQ-017 stall_cnt  out  CNT_W  saturating count of frozen cycles.

Function
REQ-018 FSM states RUN, MWAIT, ERR; state, timeout counter, err and stall_cnt are the only registers.
REQ-019 mem_acc = mem_is_load | mem_is_store.
REQ-020 RUN: dmem_req = mem_acc; advance = !mem_acc | dmem_ack.
REQ-021 RUN, mem_acc & !dmem_ack -> MWAIT next cycle, timeout counter cleared to 0.
REQ-022 MWAIT: dmem_req = 1; advance = dmem_ack; on dmem_ack -> RUN.
REQ-023 MWAIT, no ack: counter increments; ack absent in the cycle counter == TIMEOUT-1 -> ERR next cycle.
REQ-024 Ack in the same cycle as counter reaching TIMEOUT-1: ack wins, -> RUN, err stays 0.
REQ-025 ERR: dmem_req = 0, advance = 0, err = 1; left only by rst.
REQ-026 pc_en = ifid_en = exmem_en = advance (combinational, same cycle).
REQ-027 ifid_flush = ex_br_taken & advance; a branch held in EX during MWAIT flushes only on the advancing cycle.
REQ-028 fwd_a = 01 if ex_use_rs1 & mem_reg_wr & !mem_is_load & mem_rd == ex_rs1 & mem_rd != 0; 10 if same match but mem_is_load; else 00. fwd_b identical using rs2.
REQ-029 fwd_a/fwd_b are combinational, valid in all states; rd == x0 never forwards.
REQ-030 stall_cnt += 1 in every cycle with advance = 0 and not in rst; saturates at all-ones, no wrap.
REQ-031 Load forwarding (10) is meaningful only in the cycle dmem_ack = 1; EX holds during MWAIT since EX_MEM is frozen.

Reset
REQ-032 While rst = 1: state <= RUN, counter <= 0, err <= 0, stall_cnt <= 0.
REQ-033 While rst = 1: dmem_req, pc_en, ifid_en, exmem_en, ifid_flush all forced 0; fwd_a/fwd_b = 00.
REQ-034 rst asserted in MWAIT or ERR aborts the access; the first cycle after release is RUN with the REQ-020 outputs.

Verification
REQ-035 ALU op in EX_MEM, rd = 5; EX uses rs1 = 5 -> fwd_a = 01, fwd_b = 00, all enables 1, dmem_req 0.
REQ-036 Load rd = 0 in EX_MEM, ex_rs1 = 0, ack same cycle -> fwd_a = 00, dmem_req 1, enables 1, stall_cnt unchanged.
REQ-037 Store, ack after 3 cycles -> dmem_req 1 for 4 cycles, enables 0 for 3 then 1, stall_cnt = 3, state back to RUN.
REQ-038 ex_br_taken = 1 during the 2-cycle MWAIT of a load -> ifid_flush 0, 0, then 1 on the ack cycle, together with enables = 1.
REQ-039 TIMEOUT = 4, load with no ack -> ERR entered 5 cycles after the request began, err = 1, enables 0, dmem_req 0; rst pulse -> err 0, state RUN.
REQ-040 CNT_W = 4, 20 frozen cycles -> stall_cnt stops at 15, no wrap.
